// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register addressing and scoreboard sizing.
package cpu_pkg;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t REG_SP = 4'd13;
  localparam reg_addr_t REG_PC = 4'd15;

  localparam int SB_CNT_W   = 2;
  localparam int SB_CNT_MAX = (1 << SB_CNT_W) - 1;

endpackage

// File: rtl/sb_counter.sv
// Saturating in-flight write counter for one architectural register.
// Simultaneous inc and dec cancel. Overflow and underflow hold the count
// and raise err_o for that cycle.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] next_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count with saturation at both ends; err flags an illegal request
  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) err_o = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_o = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign next_o  = cnt_d;

endmodule

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: counts writes in flight between decode and
// write-back and raises a same-cycle hazard when a decoded source still
// has a write outstanding. The PC (r15) is never tracked.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREGS     = 16,
  parameter int CNT_W     = SB_CNT_W,
  parameter int WB_BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall,
  input  logic             i_issue_en,
  input  logic [3:0]       i_issue_rd,
  input  logic             i_rs_a_en,
  input  logic [3:0]       i_rs_a,
  input  logic             i_rs_b_en,
  input  logic [3:0]       i_rs_b,
  input  logic             i_wb_en,
  input  logic [3:0]       i_wb_rd,
  output logic             o_hazard,
  output logic [NREGS-1:0] o_pending_r,
  output logic             o_busy_r,
  output logic             o_err_r
);

  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0][CNT_W-1:0] cnt_nx;
  logic [NREGS-1:0]            err_vec;
  logic [NREGS-1:0]            pend_d;
  logic                        issue_acc;
  logic                        hz_a, hz_b;

  logic [NREGS-1:0] pending_q;
  logic             busy_q;
  logic             err_q;

  // One counter per tracked register; the top slot (PC) stays empty
  genvar gi;
  generate
    for (gi = 0; gi < NREGS - 1; gi++) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (issue_acc && (i_issue_rd == reg_addr_t'(gi))),
        .dec_i   (i_wb_en && (i_wb_rd == reg_addr_t'(gi))),
        .count_o (cnt[gi]),
        .next_o  (cnt_nx[gi]),
        .err_o   (err_vec[gi])
      );
      assign pend_d[gi] = |cnt_nx[gi];
    end
  endgenerate

  assign cnt[NREGS-1]     = '0;
  assign cnt_nx[NREGS-1]  = '0;
  assign err_vec[NREGS-1] = 1'b0;
  assign pend_d[NREGS-1]  = 1'b0;

  // Source hazards; a write-back retiring the last pending write bypasses
  always_comb begin
    hz_a = i_rs_a_en && (i_rs_a != REG_PC) && (cnt[i_rs_a] != '0);
    if ((WB_BYPASS != 0) && i_wb_en && (i_wb_rd == i_rs_a) &&
        (cnt[i_rs_a] == CNT_W'(1)))
      hz_a = 1'b0;
    hz_b = i_rs_b_en && (i_rs_b != REG_PC) && (cnt[i_rs_b] != '0);
    if ((WB_BYPASS != 0) && i_wb_en && (i_wb_rd == i_rs_b) &&
        (cnt[i_rs_b] == CNT_W'(1)))
      hz_b = 1'b0;
  end

  assign o_hazard  = hz_a || hz_b;
  assign issue_acc = i_issue_en && !i_stall && !o_hazard && (i_issue_rd != REG_PC);

  // Status registers track post-update counts; error is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pend_d;
      busy_q    <= |pend_d;
      err_q     <= err_q || (|err_vec);
    end
  end

  assign o_pending_r = pending_q;
  assign o_busy_r    = busy_q;
  assign o_err_r     = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with an in-bench counting model.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_issue_en = 1'b0;
  logic [3:0]  i_issue_rd = '0;
  logic        i_rs_a_en = 1'b0;
  logic [3:0]  i_rs_a = '0;
  logic        i_rs_b_en = 1'b0;
  logic [3:0]  i_rs_b = '0;
  logic        i_wb_en = 1'b0;
  logic [3:0]  i_wb_rd = '0;
  logic        o_hazard;
  logic [15:0] o_pending_r;
  logic        o_busy_r;
  logic        o_err_r;

  int passed = 0;
  int total  = 0;

  reg_scoreboard #(.NREGS(16), .CNT_W(2), .WB_BYPASS(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_stall     (i_stall),
    .i_issue_en  (i_issue_en),
    .i_issue_rd  (i_issue_rd),
    .i_rs_a_en   (i_rs_a_en),
    .i_rs_a      (i_rs_a),
    .i_rs_b_en   (i_rs_b_en),
    .i_rs_b      (i_rs_b),
    .i_wb_en     (i_wb_en),
    .i_wb_rd     (i_wb_rd),
    .o_hazard    (o_hazard),
    .o_pending_r (o_pending_r),
    .o_busy_r    (o_busy_r),
    .o_err_r     (o_err_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt [16];
  bit m_err;

  function automatic bit m_src_hz(input bit en, input int s);
    if (!en || s == 15 || m_cnt[s] == 0) return 1'b0;
    if (i_wb_en && int'(i_wb_rd) == s && m_cnt[s] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_hazard();
    return m_src_hz(i_rs_a_en, int'(i_rs_a)) || m_src_hz(i_rs_b_en, int'(i_rs_b));
  endfunction

  function automatic logic [15:0] m_pending();
    logic [15:0] m = '0;
    for (int n = 0; n < 16; n++) m[n] = (m_cnt[n] != 0);
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 16; n++) m_cnt[n] = 0;
      m_err = 1'b0;
    end else begin
      bit acc;
      acc = i_issue_en && !i_stall && !m_hazard() && i_issue_rd != 4'd15;
      for (int n = 0; n < 15; n++) begin
        bit inc, dec;
        inc = acc && int'(i_issue_rd) == n;
        dec = i_wb_en && int'(i_wb_rd) == n;
        if (inc && !dec) begin
          if (m_cnt[n] == 3) m_err = 1'b1; else m_cnt[n]++;
        end else if (dec && !inc) begin
          if (m_cnt[n] == 0) m_err = 1'b1; else m_cnt[n]--;
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge
  always @(negedge clk) begin
    chk("hazard",  {31'd0, o_hazard}, {31'd0, m_hazard()});
    chk("pending", {16'd0, o_pending_r}, {16'd0, m_pending()});
    chk("busy",    {31'd0, o_busy_r}, {31'd0, (m_pending() != 16'd0)});
    chk("err",     {31'd0, o_err_r}, {31'd0, m_err});
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit stall, input bit ie, input int rd,
                       input bit ae, input int a, input bit be, input int b,
                       input bit we, input int wrd);
    i_stall = stall; i_issue_en = ie; i_issue_rd = 4'(rd);
    i_rs_a_en = ae; i_rs_a = 4'(a); i_rs_b_en = be; i_rs_b = 4'(b);
    i_wb_en = we; i_wb_rd = 4'(wrd);
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0; #3; rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2 rst_n = 1'b1;
    tick();

    // 1: async reset in the middle of traffic
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 2, 0, 0, 0, 0, 1, 7); tick();  // wb to empty reg -> err
    drive(0, 0, 0, 1, 1, 1, 2, 0, 0);
    chk("t1_pre_hazard", {31'd0, o_hazard}, 32'd1);
    chk("t1_pre_pending", {16'd0, o_pending_r}, 32'h0006);
    #1 rst_n = 1'b0; #1;
    chk("t1_rst_hazard", {31'd0, o_hazard}, 32'd0);
    chk("t1_rst_pending", {16'd0, o_pending_r}, 32'd0);
    chk("t1_rst_busy", {31'd0, o_busy_r}, 32'd0);
    chk("t1_rst_err", {31'd0, o_err_r}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    chk("t1_rel_hazard", {31'd0, o_hazard}, 32'd0);

    // 2: issue r3, read r3, WB bypass
    do_reset();
    drive(0, 1, 3, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 3, 0, 0, 0, 0);
    chk("t2_hazard", {31'd0, o_hazard}, 32'd1);
    chk("t2_pending", {16'd0, o_pending_r}, 32'h0008);
    tick();
    drive(0, 1, 6, 1, 3, 0, 0, 0, 0);          // blocked by hazard
    tick();
    drive(0, 0, 0, 1, 3, 0, 0, 1, 3);
    chk("t2_bypass", {31'd0, o_hazard}, 32'd0);
    tick();
    idle();
    chk("t2_clear", {16'd0, o_pending_r}, 32'd0);
    chk("t2_busy", {31'd0, o_busy_r}, 32'd0);

    // 3: saturate r5
    do_reset();
    repeat (3) begin drive(0, 1, 5, 0, 0, 0, 0, 0, 0); tick(); end
    idle();
    chk("t3_err0", {31'd0, o_err_r}, 32'd0);
    chk("t3_pend5", {16'd0, o_pending_r}, 32'h0020);
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0); tick();
    idle();
    chk("t3_err1", {31'd0, o_err_r}, 32'd1);
    drive(0, 0, 0, 1, 5, 0, 0, 1, 5);
    chk("t3_no_bypass_cnt3", {31'd0, o_hazard}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5); tick();
    idle();
    chk("t3_cnt1_left", {16'd0, o_pending_r}, 32'h0020);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5); tick();
    idle();
    chk("t3_cnt0", {16'd0, o_pending_r}, 32'd0);

    // 4: issue and WB to r2 in the same cycle
    do_reset();
    drive(0, 1, 2, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 2, 0, 0, 0, 0, 1, 2); tick();
    idle();
    chk("t4_pend2", {16'd0, o_pending_r}, 32'h0004);
    chk("t4_err", {31'd0, o_err_r}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2); tick();
    idle();
    chk("t4_drain", {16'd0, o_pending_r}, 32'd0);
    chk("t4_err_after", {31'd0, o_err_r}, 32'd0);

    // 5: stalled issue ignored, WB with count 0 flags error
    do_reset();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0); tick();
    idle();
    chk("t5_stall", {16'd0, o_pending_r}, 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 4); tick();
    idle();
    chk("t5_underflow", {31'd0, o_err_r}, 32'd1);

    // 6: PC never tracked, SP tracked
    do_reset();
    drive(0, 1, 15, 0, 0, 1, 15, 0, 0);
    chk("t6_pc_hz", {31'd0, o_hazard}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 15, 0, 0);
    chk("t6_pc_pend", {16'd0, o_pending_r}, 32'd0);
    chk("t6_pc_hz2", {31'd0, o_hazard}, 32'd0);
    drive(0, 1, 13, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 13, 0, 0, 0, 0);
    chk("t6_sp_hz", {31'd0, o_hazard}, 32'd1);
    tick();

    // Mixed traffic against the model
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)));
      tick();
    end
    idle(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
